// File: rtl/bkadder_pipe.sv
// Three-stage Brent-Kung adder with valid/ready flow control.
// Optional subtract path: define BKADDER_SUB_EN to add the sub port.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   sub                  subtract select (BKADDER_SUB_EN only)
//   in_valid, in_ready   operand handshake
//   a, b, cin            operands and carry-in
//   out_valid, out_ready result handshake
//   s, cout, ovf         sum, carry-out, signed overflow
module bkadder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef BKADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int LG = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } s0_t;

  typedef struct packed {
    logic [WIDTH-1:0] gt;
    logic [WIDTH-1:0] pt;
    logic [WIDTH-1:0] p;
    logic             cin;
  } s1_t;

  s0_t s0;
  s1_t s1;
  logic v0, v1, v2;
  logic adv;

`ifdef BKADDER_SUB_EN
  logic s0_sub;
`endif

  // One stall signal freezes every stage
  assign adv       = !v2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v2;

  logic [WIDTH-1:0] bx, pb;
  logic [WIDTH-1:0] g_up, p_up;
  logic             cx;

  // Up-sweep: node i covers a power-of-two span
  always_comb begin
    bx = s0.b;
    cx = s0.cin;
`ifdef BKADDER_SUB_EN
    if (s0_sub) begin
      bx = ~s0.b;
      cx = ~s0.cin;
    end
`endif
    pb   = s0.a ^ bx;
    g_up = s0.a & bx;
    p_up = pb;
    for (int l = 1; l <= LG; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          g_up[i] = g_up[i]
                  | (p_up[i] & g_up[i - (1 << (l - 1))]);
          p_up[i] = p_up[i] & p_up[i - (1 << (l - 1))];
        end
      end
    end
  end

  logic [WIDTH-1:0] g_dn, p_dn;
  logic [WIDTH:0]   c;

  // Down-sweep fills odd multiples of each span,
  // widest span first, so every node ends as [i:0]
  always_comb begin
    g_dn = s1.gt;
    p_dn = s1.pt;
    for (int l = LG - 1; l >= 1; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i + 1) >= 3 * (1 << (l - 1)) &&
            ((i + 1) % (1 << l)) == (1 << (l - 1))) begin
          g_dn[i] = g_dn[i]
                  | (p_dn[i] & g_dn[i - (1 << (l - 1))]);
          p_dn[i] = p_dn[i] & p_dn[i - (1 << (l - 1))];
        end
      end
    end
    c[0] = s1.cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i + 1] = g_dn[i] | (p_dn[i] & s1.cin);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      s0   <= '0;
      s1   <= '0;
      s    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
`ifdef BKADDER_SUB_EN
      s0_sub <= 1'b0;
`endif
    end else if (adv) begin
      v0 <= in_valid;
      v1 <= v0;
      v2 <= v1;
      if (in_valid) begin
        s0.a   <= a;
        s0.b   <= b;
        s0.cin <= cin;
`ifdef BKADDER_SUB_EN
        s0_sub <= sub;
`endif
      end
      s1.gt  <= g_up;
      s1.pt  <= p_up;
      s1.p   <= pb;
      s1.cin <= cx;
      s      <= s1.p ^ c[WIDTH-1:0];
      cout   <= c[WIDTH];
      ovf    <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

endmodule
